pipeline_hazard_ctrl: RTL and testbench

//  Sequencing controller for the 5-stage pipelined MIPS datapath. It sits beside

---
 rtl/pipeline_hazard_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, taken-branch squash, EX operand
// forwarding, halt/drain/resume sequencing and saturating stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int              OP_W         = 4,
    parameter int              REG_AW       = 3,
    parameter logic [OP_W-1:0] HALT_OP      = 4'hF,
    parameter int              DRAIN_CYCLES = 3,
    parameter int              CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [OP_W-1:0]   id_op,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_branch_taken,
    input  logic              mem_we,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              resume,
    input  logic              clr_cnt,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              halted,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // state | meaning
    // RUN   | normal issue; hazards and halt requests evaluated
    // DRAIN | halt op held in ID, older instructions retiring
    // HALT  | pipeline frozen until resume
    typedef enum logic [1:0] {
        RUN   = 2'b00,
        DRAIN = 2'b01,
        HALT  = 2'b10
    } state_t;

    localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES - 1);

    state_t     st, st_nxt;
    logic [2:0] dcnt, dcnt_nxt;
    logic       lu, halt_req, stall_inc, flush_inc;
    logic [1:0] fa, fb;

    assign lu = id_valid & ex_mem_read & (ex_rd != '0) &
                ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));
    assign halt_req = id_valid & (id_op == HALT_OP);

    // EX/MEM is the younger result, so it wins over MEM/WB
    always_comb begin
        fa = 2'b00;
        fb = 2'b00;
        if (mem_we && mem_rd != '0 && mem_rd == ex_rs)
            fa = 2'b10;
        else if (wb_we && wb_rd != '0 && wb_rd == ex_rs)
            fa = 2'b01;
        if (mem_we && mem_rd != '0 && mem_rd == ex_rt)
            fb = 2'b10;
        else if (wb_we && wb_rd != '0 && wb_rd == ex_rt)
            fb = 2'b01;
    end

    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        st_nxt     = st;
        dcnt_nxt   = dcnt;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        case (st)
            DRAIN: begin
                if (ex_branch_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    flush_inc  = 1'b1;
                    st_nxt     = RUN;
                end else begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                    if (dcnt == 3'd0)
                        st_nxt = HALT;
                    else
                        dcnt_nxt = dcnt - 3'd1;
                end
            end
            HALT: begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
                if (resume) begin
                    ifid_flush = 1'b1;
                    pc_en      = 1'b1;
                    st_nxt     = RUN;
                end
            end
            default: begin
                // the unused encoding behaves as RUN and settles there
                st_nxt = RUN;
                if (ex_branch_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    flush_inc  = 1'b1;
                end else if (lu) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                    stall_inc  = 1'b1;
                end else if (halt_req) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                    dcnt_nxt   = DRAIN_INIT;
                    st_nxt     = DRAIN;
                end
            end
        endcase
        if (reset) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end
    end

    assign fwd_a  = reset ? 2'b00 : fa;
    assign fwd_b  = reset ? 2'b00 : fb;
    assign halted = (st == HALT);
    assign state  = st;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st        <= RUN;
            dcnt      <= 3'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            st   <= st_nxt;
            dcnt <= dcnt_nxt;
            if (clr_cnt)
                stall_cnt <= '0;
            else if (stall_inc && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (clr_cnt)
                flush_cnt <= '0;
            else if (flush_inc && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_pipeline_hazard_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       id_valid = 0, id_uses_rt = 0, ex_mem_read = 0, ex_branch_taken = 0;
    logic       mem_we = 0, wb_we = 0, resume = 0, clr_cnt = 0;
    logic [3:0] id_op = 0;
    logic [2:0] id_rs = 0, id_rt = 0, ex_rs = 0, ex_rt = 0, ex_rd = 0, mem_rd = 0, wb_rd = 0;
    logic       pc_en, ifid_en, ifid_flush, idex_flush, halted;
    logic [1:0] fwd_a, fwd_b, state;
    logic [15:0] stall_cnt, flush_cnt;

    int tests = 0;
    int fails = 0;

    pipeline_hazard_ctrl dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_op(id_op), .id_rs(id_rs),
        .id_rt(id_rt), .id_uses_rt(id_uses_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
        .mem_we(mem_we), .mem_rd(mem_rd), .wb_we(wb_we), .wb_rd(wb_rd),
        .resume(resume), .clr_cnt(clr_cnt), .pc_en(pc_en), .ifid_en(ifid_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .halted(halted), .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model, checked every negedge ----------------
    int m_mode = 0;      // 0 run, 1 drain, 2 halt
    int m_left = 0;      // drain cycles still to go after the current one
    int m_sc = 0, m_fc = 0;

    function automatic int fwd_of(input int src);
        if (mem_we && mem_rd != 0 && int'(mem_rd) == src) return 2;
        if (wb_we && wb_rd != 0 && int'(wb_rd) == src) return 1;
        return 0;
    endfunction

    always @(negedge clk) begin
        int e_pc, e_en, e_iff, e_xf, e_fa, e_fb, nxt, sinc, finc;
        bit lu_m, hlt_m;
        if (reset) begin
            m_mode = 0; m_left = 0; m_sc = 0; m_fc = 0;
            chk("m_rst_pc_en", pc_en, 0);
            chk("m_rst_ifid_en", ifid_en, 0);
            chk("m_rst_ifid_flush", ifid_flush, 1);
            chk("m_rst_idex_flush", idex_flush, 1);
            chk("m_rst_fwd", {fwd_a, fwd_b}, 0);
            chk("m_rst_state", state, 0);
            chk("m_rst_halted", halted, 0);
            chk("m_rst_cnt", stall_cnt + flush_cnt, 0);
        end else begin
            e_pc = 1; e_en = 1; e_iff = 0; e_xf = 0; nxt = m_mode; sinc = 0; finc = 0;
            e_fa = fwd_of(ex_rs);
            e_fb = fwd_of(ex_rt);
            lu_m = id_valid && ex_mem_read && ex_rd != 0 &&
                   (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
            hlt_m = id_valid && id_op == 4'hF;
            if (m_mode != 2 && ex_branch_taken) begin
                e_iff = 1; e_xf = 1; finc = 1; nxt = 0;
            end else if (m_mode == 1) begin
                e_pc = 0; e_en = 0; e_xf = 1;
                if (m_left == 0) nxt = 2; else m_left--;
            end else if (m_mode == 2) begin
                e_pc = resume ? 1 : 0; e_en = 0; e_xf = 1; e_iff = resume ? 1 : 0;
                if (resume) nxt = 0;
            end else if (lu_m) begin
                e_pc = 0; e_en = 0; e_xf = 1; sinc = 1;
            end else if (hlt_m) begin
                e_pc = 0; e_en = 0; e_xf = 1; nxt = 1; m_left = 2;
            end
            chk("m_pc_en", pc_en, e_pc);
            chk("m_ifid_en", ifid_en, e_en);
            chk("m_ifid_flush", ifid_flush, e_iff);
            chk("m_idex_flush", idex_flush, e_xf);
            chk("m_fwd_a", fwd_a, e_fa);
            chk("m_fwd_b", fwd_b, e_fb);
            chk("m_state", state, m_mode);
            chk("m_halted", halted, m_mode == 2 ? 1 : 0);
            chk("m_stall_cnt", stall_cnt, m_sc);
            chk("m_flush_cnt", flush_cnt, m_fc);
            m_mode = nxt;
            if (clr_cnt) begin
                m_sc = 0; m_fc = 0;
            end else begin
                if (sinc) m_sc = (m_sc + 1 > 65535) ? 65535 : m_sc + 1;
                if (finc) m_fc = (m_fc + 1 > 65535) ? 65535 : m_fc + 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        id_valid = 0; id_op = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
        ex_rs = 0; ex_rt = 0; ex_mem_read = 0; ex_rd = 0; ex_branch_taken = 0;
        mem_we = 0; mem_rd = 0; wb_we = 0; wb_rd = 0; resume = 0; clr_cnt = 0;
    endtask

    task automatic drive_lu;
        idle;
        ex_mem_read = 1; ex_rd = 3; id_valid = 1; id_op = 0;
        id_rs = 3; id_rt = 2; id_uses_rt = 1;
    endtask

    initial begin
        idle;
        mem_we = 1; mem_rd = 5; ex_rs = 5;
        #2;
        chk("rst_pc_en", pc_en, 0);
        chk("rst_ifid_flush", ifid_flush, 1);
        chk("rst_fwd_a", fwd_a, 0);
        chk("rst_state", state, 0);
        tick;
        reset = 0;
        idle;

        // load-use on r3, then forwarding from EX/MEM
        drive_lu;
        #3;
        chk("lu_pc_en", pc_en, 0);
        chk("lu_ifid_en", ifid_en, 0);
        chk("lu_idex_flush", idex_flush, 1);
        tick;
        idle; mem_we = 1; mem_rd = 3; ex_rs = 3;
        #3;
        chk("lu_after_pc_en", pc_en, 1);
        chk("lu_after_fwd_a", fwd_a, 2);
        chk("lu_stall_cnt", stall_cnt, 1);

        // load into r0 is not a hazard
        tick;
        idle; ex_mem_read = 1; ex_rd = 0; id_valid = 1; id_uses_rt = 1;
        #3;
        chk("r0_pc_en", pc_en, 1);
        tick;
        idle;
        #3;
        chk("r0_stall_cnt", stall_cnt, 1);

        // taken branch beats load-use and halt
        drive_lu; ex_branch_taken = 1; id_op = 4'hF;
        #3;
        chk("br_flushes", {ifid_flush, idex_flush, pc_en}, 3'b111);
        tick;
        idle;
        #3;
        chk("br_flush_cnt", flush_cnt, 1);
        chk("br_state", state, 0);
        chk("br_stall_cnt", stall_cnt, 1);

        // halt, three drain cycles, halt, resume
        id_valid = 1; id_op = 4'hF;
        #3;
        chk("halt_req_pc_en", pc_en, 0);
        tick;
        idle;
        for (int i = 0; i < 3; i++) begin
            #3;
            chk("drain_state", state, 1);
            tick;
        end
        #3;
        chk("halt_state", state, 2);
        chk("halt_halted", halted, 1);
        tick;
        resume = 1;
        #3;
        chk("resume_outputs", {ifid_flush, pc_en, halted}, 3'b111);
        tick;
        resume = 0;
        #3;
        chk("resume_state", state, 0);
        chk("resume_halted", halted, 0);

        // forwarding priority
        tick;
        mem_we = 1; wb_we = 1; mem_rd = 5; wb_rd = 5; ex_rs = 5; ex_rt = 5;
        #3;
        chk("fwd_both_a", fwd_a, 2);
        chk("fwd_both_b", fwd_b, 2);
        tick;
        mem_we = 0;
        #3;
        chk("fwd_wb_a", fwd_a, 1);
        tick;
        idle;

        // stall counter saturation and clear
        drive_lu;
        repeat (65533) tick;
        idle;
        #3;
        chk("sat_fffe", stall_cnt, 16'hFFFE);
        drive_lu;
        repeat (3) tick;
        idle;
        #3;
        chk("sat_ffff", stall_cnt, 16'hFFFF);
        drive_lu; clr_cnt = 1;
        tick;
        idle;
        #3;
        chk("clr_beats_inc", stall_cnt, 0);

        // reset while draining
        id_valid = 1; id_op = 4'hF;
        tick;
        idle;
        #3;
        chk("pre_rst_drain", state, 1);
        reset = 1;
        #3;
        chk("rst_drain_state", state, 0);
        chk("rst_drain_halted", halted, 0);
        tick;
        reset = 0;

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            tick;
            id_valid        = ($urandom_range(0, 3) != 0);
            id_op           = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            id_rs           = 3'($urandom_range(0, 7));
            id_rt           = 3'($urandom_range(0, 7));
            id_uses_rt      = 1'($urandom_range(0, 1));
            ex_rs           = 3'($urandom_range(0, 7));
            ex_rt           = 3'($urandom_range(0, 7));
            ex_rd           = 3'($urandom_range(0, 7));
            ex_mem_read     = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            mem_we          = 1'($urandom_range(0, 1));
            mem_rd          = 3'($urandom_range(0, 7));
            wb_we           = 1'($urandom_range(0, 1));
            wb_rd           = 3'($urandom_range(0, 7));
            resume          = ($urandom_range(0, 3) == 0);
            clr_cnt         = ($urandom_range(0, 63) == 0);
            reset           = ($urandom_range(0, 199) == 0);
        end
        tick;
        idle; reset = 0;
        tick;
        tick;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
